dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-ported 512-word data memory between two requesters: port 0 (CPU load/store stage) and port 1 (debug/loader).
- Each port uses a req/ack handshake. The memory side is a variable-latency en/ready interface.
- Provides round-robin arbitration, address range checking and a ready-timeout watchdog.
- Sits between the CPU datapath and the data memory array.

Parameters:
- DEPTH, 512, number of 32-bit words in data memory; valid word addresses are 0..DEPTH-1.
- ADDR_W, 32, width of the word address on requester and memory ports.
- TIMEOUT, 15, maximum cycles ACCESS waits for mem_ready before aborting; range 1..255.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- req  input  2  per-port request; bit0 = CPU, bit1 = debug.
- we  input  2  per-port write enable (1 = store, 0 = load).
- addr0, addr1  input  ADDR_W each  per-port word address.
- wdata0, wdata1  input  32 each  per-port store data.
- ack  output  2  one-cycle completion pulse, one bit per port.
- err  output  1  pulses with ack when the access was aborted.
- rdata  output  32  load data, valid in the ack cycle.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory word address.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data, valid when mem_ready=1.
- mem_ready  input  1  memory completion; sampled only in ACCESS.

Behaviour:
- Reset: synchronous, active-high. The clock and reset are fixed as single clk and synchronous active-high reset. On reset: state=IDLE, ack=0, err=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, last_grant=1 (so port 0 wins first), wait counter=0. Reset during any state aborts the transaction with no ack.
- Registers: all outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req bit is set, pick the owner.
  - Single requester: that port wins.
  - Both requesting: the port not equal to last_grant wins.
  - On grant, latch the owner's addr, we and wdata; set last_grant=owner.
  - If the latched addr >= DEPTH, go to RESP with err_pending=1 and issue no memory access.
  - Otherwise go to ACCESS with mem_en=1, mem_we=we, mem_addr=addr, mem_wdata=wdata.
- ACCESS:
  - mem_en, mem_we, mem_addr and mem_wdata are held stable.
  - If mem_ready=1: capture mem_rdata (loads only; stores capture 0), go to RESP, drop mem_en.
  - Otherwise increment the wait counter. When counter==TIMEOUT, drop mem_en, set err_pending=1, rdata=0, go to RESP.
- RESP:
  - ack[owner]=1 and err=err_pending for exactly one cycle; rdata holds its value.
  - Next state is IDLE; clear the counter and err_pending. ack returns to 0.
- Latency: request seen in IDLE at cycle T, mem_ready=1 at T+1, ack at T+2. Minimum is 2 cycles; the worst case for a valid address is TIMEOUT+2.
- Requester rule: req, we, addr and wdata must stay stable from assertion until the ack cycle. Values are latched at grant, so later changes are ignored. A port may hold req high through ack to request again; it is re-arbitrated in the IDLE cycle after RESP.
- Non-owner requests are ignored until IDLE; no ack is given to them.
- Only one transaction is ever outstanding. ack is one-hot or zero.
- rdata after a store or error is 0. rdata is never updated outside RESP entry.
- mem_ready asserted outside ACCESS is ignored.

Optional Feature:
- Macro: DMEM_CPU_PRIORITY_EN.
- Defined: fixed priority. When both ports request in IDLE, port 0 always wins; last_grant is unused. Port 1 may starve.
- Not defined: round-robin as described above.

Test Plan:
- Reset then req=01, we=0, addr0=5, mem_ready=1 in the first ACCESS cycle, mem_rdata=0xDEADBEEF -> mem_en=1 and mem_addr=5 for 1 cycle; ack=01, rdata=0xDEADBEEF, err=0 exactly 2 cycles after req.
- req=10, we=10, addr1=511, wdata1=0x12345678, mem_ready delayed 3 cycles -> mem_en/mem_we high 4 cycles, mem_wdata=0x12345678; ack=10, rdata=0.
- req=11 held for three transactions (round-robin build) -> grant order 0,1,0; ack sequence 01,10,01. Under DMEM_CPU_PRIORITY_EN -> 01,01,01.
- req=01, addr0=512 -> mem_en never asserted; ack=01, err=1, rdata=0, 1 cycle after req.
- req=01, mem_ready held 0, TIMEOUT=15 -> mem_en high for 16 cycles then drops; ack=01, err=1 the cycle after.
- reset asserted mid-ACCESS -> next cycle state IDLE, mem_en=0, no ack; a following req=01 completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-ported data memory, with address range
// check and mem_ready watchdog. Define DMEM_CPU_PRIORITY_EN for fixed CPU priority.
module dmem_arbiter #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

  state_t            stateQ, stateD;
  logic              ownerQ, ownerD;
  logic              lastGrantQ, lastGrantD;
  logic [7:0]        cntQ, cntD;
  logic [1:0]        ackQ, ackD;
  logic              errQ, errD;
  logic [31:0]       rdataQ, rdataD;
  logic              memEnQ, memEnD;
  logic              memWeQ, memWeD;
  logic [ADDR_W-1:0] memAddrQ, memAddrD;
  logic [31:0]       memWdataQ, memWdataD;

  logic              grantPort;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [31:0]       selWdata;

  always_comb begin
`ifdef DMEM_CPU_PRIORITY_EN
    grantPort = req[0] ? 1'b0 : 1'b1;
`else
    // Contention goes to whichever port did not win last time.
    if (req == 2'b11) begin
      grantPort = ~lastGrantQ;
    end else begin
      grantPort = req[1];
    end
`endif
    selWe    = grantPort ? we[1]  : we[0];
    selAddr  = grantPort ? addr1  : addr0;
    selWdata = grantPort ? wdata1 : wdata0;
  end

  always_comb begin
    stateD     = stateQ;
    ownerD     = ownerQ;
    lastGrantD = lastGrantQ;
    cntD       = cntQ;
    ackD       = 2'b00;
    errD       = 1'b0;
    rdataD     = rdataQ;
    memEnD     = memEnQ;
    memWeD     = memWeQ;
    memAddrD   = memAddrQ;
    memWdataD  = memWdataQ;

    unique case (stateQ)
      StIdle: begin
        if (|req) begin
          ownerD     = grantPort;
          lastGrantD = grantPort;
          if (selAddr >= ADDR_W'(DEPTH)) begin
            // Out-of-range address: answer with an error, never touch the memory.
            stateD          = StResp;
            ackD[grantPort] = 1'b1;
            errD            = 1'b1;
            rdataD          = '0;
          end else begin
            stateD    = StAccess;
            cntD      = '0;
            memEnD    = 1'b1;
            memWeD    = selWe;
            memAddrD  = selAddr;
            memWdataD = selWdata;
          end
        end
      end

      StAccess: begin
        if (mem_ready) begin
          stateD       = StResp;
          ackD[ownerQ] = 1'b1;
          rdataD       = memWeQ ? 32'd0 : mem_rdata;
          memEnD       = 1'b0;
          memWeD       = 1'b0;
        end else if (cntQ == 8'(TIMEOUT)) begin
          stateD       = StResp;
          ackD[ownerQ] = 1'b1;
          errD         = 1'b1;
          rdataD       = '0;
          memEnD       = 1'b0;
          memWeD       = 1'b0;
        end else begin
          cntD = cntQ + 8'd1;
        end
      end

      StResp: begin
        stateD = StIdle;
        cntD   = '0;
      end

      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= StIdle;
      ownerQ     <= 1'b0;
      lastGrantQ <= 1'b1;
      cntQ       <= '0;
      ackQ       <= '0;
      errQ       <= 1'b0;
      rdataQ     <= '0;
      memEnQ     <= 1'b0;
      memWeQ     <= 1'b0;
      memAddrQ   <= '0;
      memWdataQ  <= '0;
    end else begin
      stateQ     <= stateD;
      ownerQ     <= ownerD;
      lastGrantQ <= lastGrantD;
      cntQ       <= cntD;
      ackQ       <= ackD;
      errQ       <= errD;
      rdataQ     <= rdataD;
      memEnQ     <= memEnD;
      memWeQ     <= memWeD;
      memAddrQ   <= memAddrD;
      memWdataQ  <= memWdataD;
    end
  end

  assign ack       = ackQ;
  assign err       = errQ;
  assign rdata     = rdataQ;
  assign mem_en    = memEnQ;
  assign mem_we    = memWeQ;
  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: random traffic, a memory responder with chosen
// ready delays, and a monitor that checks every ack against the queued expectation.
module tb_dmem_arbiter;

  localparam int unsigned DEPTH   = 512;
  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  dmem_arbiter #(.DEPTH(DEPTH), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .err(err), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          en;
    int          issue;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          d;
    logic [31:0] rd;
  } acc_t;

  exp_t expQ[$];
  acc_t accQ[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lastGrant = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Reference: memory answers on wait cycle d+1; the watchdog gives up after TIMEOUT+1.
  task automatic plan(input int p, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input int d, input logic [31:0] rd, input bit withLat);
    exp_t e;
    acc_t c;
    bit   isBad;
    int   n;
    isBad   = (a >= DEPTH);
    n       = (d > int'(TIMEOUT)) ? int'(TIMEOUT) + 1 : d + 1;
    e.ack   = (p == 0) ? 2'b01 : 2'b10;
    e.err   = isBad || (d > int'(TIMEOUT));
    e.rdata = (e.err || w) ? 32'd0 : rd;
    e.en    = isBad ? 0 : n;
    e.lat   = !withLat ? -1 : (isBad ? 1 : n + 1);
    e.issue = cyc;
    expQ.push_back(e);
    if (!isBad) begin
      c.addr = a; c.we = w; c.wdata = wd; c.d = d; c.rd = rd;
      accQ.push_back(c);
    end
  endtask

  task automatic waitAck();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ack != 2'b00) break;
    end
    if (ack == 2'b00) begin
      total++;
      bad++;
      $display("FAIL ack_wait got=none want=ack within 200 cycles");
    end
  endtask

  task automatic issue(input logic [1:0] r, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input int d0, input int d1,
                       input logic [31:0] rd0, input logic [31:0] rd1);
    int first, second;
    req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = wd0; wdata1 = wd1;
    if (r == 2'b11) begin
`ifdef DMEM_CPU_PRIORITY_EN
      first = 0;
`else
      first = (lastGrant == 0) ? 1 : 0;
`endif
      second = 1 - first;
      plan(first, first ? a1 : a0, w[first], first ? wd1 : wd0, first ? d1 : d0,
           first ? rd1 : rd0, 1'b1);
      plan(second, second ? a1 : a0, w[second], second ? wd1 : wd0, second ? d1 : d0,
           second ? rd1 : rd0, 1'b0);
      lastGrant = second;
    end else begin
      first  = r[1] ? 1 : 0;
      second = first;
      plan(first, first ? a1 : a0, w[first], first ? wd1 : wd0, first ? d1 : d0,
           first ? rd1 : rd0, 1'b1);
      lastGrant = first;
    end
    waitAck();
    req[first] = 1'b0;
    if (r == 2'b11) begin
      waitAck();
      req[second] = 1'b0;
    end
    @(negedge clk);
  endtask

  // Both ports hold req through three completions.
  task automatic held3();
    int win;
    logic [31:0] rd;
    req = 2'b11; we = 2'b00; addr0 = 32'd10; addr1 = 32'd20;
    for (int i = 0; i < 3; i++) begin
`ifdef DMEM_CPU_PRIORITY_EN
      win = 0;
`else
      win = (lastGrant == 0) ? 1 : 0;
`endif
      rd = $urandom;
      plan(win, win ? addr1 : addr0, 1'b0, 32'd0, 0, rd, 1'b0);
      lastGrant = win;
    end
    waitAck();
    waitAck();
    waitAck();
    req = 2'b00;
    @(negedge clk);
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom % 8)
      0: randAddr = DEPTH + ($urandom % 100);
      1: randAddr = DEPTH - 1;
      2: randAddr = 32'd0;
      3: randAddr = 32'hFFFF_FFFF;
      default: randAddr = $urandom % DEPTH;
    endcase
  endfunction

  function automatic int randDelay();
    case ($urandom % 10)
      0: randDelay = int'(TIMEOUT) + 1 + int'($urandom % 3);
      1: randDelay = int'(TIMEOUT);
      default: randDelay = int'($urandom % 5);
    endcase
  endfunction

  // Memory responder: holds-stable checks and ready after the planned delay.
  initial begin
    acc_t cur;
    bit   active = 1'b0;
    int   k = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
        mem_ready = 1'b0;
      end else if (mem_en) begin
        if (!active) begin
          if (accQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mem_access got=unexpected want=no access addr=%h", mem_addr);
            cur.addr = mem_addr; cur.we = mem_we; cur.wdata = mem_wdata; cur.d = 0;
            cur.rd = '0;
          end else begin
            cur = accQ.pop_front();
          end
          active = 1'b1;
          k = 1;
        end else begin
          k++;
        end
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
        mem_ready = (k == cur.d + 1);
        mem_rdata = mem_ready ? cur.rd : $urandom;
      end else begin
        active = 1'b0;
        mem_ready = $urandom_range(0, 1) == 1;
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: every ack pops one expectation.
  initial begin
    exp_t e;
    int   enCnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        enCnt = 0;
      end else begin
        if (mem_en) enCnt++;
        if (ack != 2'b00) begin
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ack_unexpected got=%b want=00", ack);
          end else begin
            e = expQ.pop_front();
            chk("ack", {30'd0, ack}, {30'd0, e.ack});
            chk("err", {31'd0, err}, {31'd0, e.err});
            chk("rdata", rdata, e.rdata);
            chk("mem_en_cycles", enCnt, e.en);
            if (e.lat >= 0) chk("latency", cyc - e.issue, e.lat);
          end
          enCnt = 0;
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);

    held3();
    issue(2'b01, 2'b00, 32'd5, 32'd0, 32'd0, 32'd0, 0, 0, 32'hDEAD_BEEF, 32'd0);
    issue(2'b10, 2'b10, 32'd0, 32'd511, 32'd0, 32'h1234_5678, 0, 3, 32'd0, $urandom);
    issue(2'b01, 2'b00, 32'd512, 32'd0, 32'd0, 32'd0, 0, 0, $urandom, 32'd0);
    issue(2'b01, 2'b00, 32'd9, 32'd0, 32'd0, 32'd0, 40, 0, $urandom, 32'd0);
    issue(2'b01, 2'b00, 32'd9, 32'd0, 32'd0, 32'd0, int'(TIMEOUT), 0, 32'hA5A5_0001, 32'd0);

    // Reset in the middle of an access: no ack, outputs cleared.
    begin
      acc_t c;
      c.addr = 32'd7; c.we = 1'b0; c.wdata = '0; c.d = 100; c.rd = '0;
      accQ.push_back(c);
      req = 2'b01; we = 2'b00; addr0 = 32'd7;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (mem_en) break;
      end
      chk("mid_mem_en", {31'd0, mem_en}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      req = 2'b00;
      @(negedge clk);
      chk("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("mid_rst_ack", {30'd0, ack}, 32'd0);
      chk("mid_rst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      lastGrant = 1;
      accQ.delete();
      @(negedge clk);
      issue(2'b01, 2'b00, 32'd3, 32'd0, 32'd0, 32'd0, 1, 0, 32'h0BAD_F00D, 32'd0);
    end

    for (int i = 0; i < 150; i++) begin
      issue(2'($urandom_range(1, 3)), 2'($urandom), randAddr(), randAddr(),
            $urandom, $urandom, randDelay(), randDelay(), $urandom, $urandom);
      repeat ($urandom % 3) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("exp_queue_empty", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
